uart_tx_serializer_gen: RTL

//  Parametrised data serializer for the UART TX path: accepts parallel words over a valid/ready

---
 rtl/uart_ser_pkg.sv | 28 ++
 rtl/uart_tx_serializer_gen_parity.sv | 20 ++
 rtl/uart_tx_serializer_gen.sv | 135 +++++++++++++
 3 files changed

// File: rtl/uart_ser_pkg.sv
// Shared types and helpers for the UART TX data serializer.
// Holds the FSM state encoding plus frame-length clamp and bit-mask helpers.
package uart_ser_pkg;

    localparam int unsigned MAX_DW = 16;

    typedef enum logic [0:0] {
        SER_IDLE  = 1'b0,
        SER_SHIFT = 1'b1
    } ser_state_t;

    // Zero or an over-long request both fall back to the full data width.
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned dw);
        return ((len == 0) || (len > dw)) ? dw : len;
    endfunction

    function automatic logic [MAX_DW-1:0] len_mask(input int unsigned len);
        logic [MAX_DW-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_DW; i++) begin
            if (i < len) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/uart_tx_serializer_gen_parity.sv
// Combinational frame parity: XOR of the active data field, inverted for odd sense.
// Only instantiated when UART_SER_PARITY_EN is defined.
module uart_ser_parity
    import uart_ser_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_W      = 4
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [LEN_W-1:0]      len,
    input  logic                  odd,
    output logic                  par
);

    logic [MAX_DW-1:0] masked;

    assign masked = MAX_DW'(data) & len_mask(32'(len));
    assign par    = (^masked) ^ odd;

endmodule

// File: rtl/uart_tx_serializer_gen.sv
// UART TX data serializer: one-deep holding buffer feeding a right-shifting frame shifter.
// Define UART_SER_PARITY_EN to build the PAR_BIT generator; otherwise PAR_BIT is tied low.
module uart_tx_serializer_gen
    import uart_ser_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter bit MSB_FIRST  = 1'b0,
    localparam int LEN_W     = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    output logic                  DATA_READY,
    output logic                  WORD_AVAIL,
    input  logic                  LOAD,
    input  logic                  SER_EN,
    input  logic [LEN_W-1:0]      CFG_LEN,
    input  logic                  CFG_PAR_ODD,
    output logic                  SER_DATA,
    output logic                  SER_BUSY,
    output logic                  SER_DONE,
    output logic                  PAR_BIT
);

    // Handshake: a word moves into the buffer on any cycle where DATA_VALID and DATA_READY
    // are both high; DATA_READY depends only on the buffer flag and reset, never on DATA_VALID.

    ser_state_t            state;
    logic                  buf_full;
    logic [DATA_WIDTH-1:0] buf_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      cnt_q;
    logic                  busy_q;
    logic                  done_q;

    logic [LEN_W-1:0]      len_eff;
    logic [LEN_W-1:0]      rev_shift;
    logic [DATA_WIDTH-1:0] rev_full;
    logic [DATA_WIDTH-1:0] load_word;
    logic                  load_fire;
    logic                  last_bit;

    assign len_eff   = LEN_W'(clamp_len(32'(CFG_LEN), DATA_WIDTH));
    assign load_fire = (state == SER_IDLE) && LOAD && buf_full;
    assign last_bit  = (cnt_q == (len_q - LEN_W'(1)));

    // Reversing the whole word and sliding it down by (DW-L) reverses just bits [L-1:0],
    // so MSB-first frames still leave the shifter through bit 0.
    assign rev_full  = {<<{buf_q}};
    assign rev_shift = LEN_W'(DATA_WIDTH) - len_eff;
    assign load_word = MSB_FIRST ? (rev_full >> rev_shift) : buf_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= SER_IDLE;
            buf_full <= 1'b0;
            buf_q    <= '0;
            shift_q  <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (DATA_VALID && !buf_full) begin
                buf_q    <= P_DATA;
                buf_full <= 1'b1;
            end
            case (state)
                SER_IDLE: begin
                    if (load_fire) begin
                        shift_q  <= load_word;
                        len_q    <= len_eff;
                        cnt_q    <= '0;
                        buf_full <= 1'b0;
                        busy_q   <= 1'b1;
                        state    <= SER_SHIFT;
                    end
                end
                SER_SHIFT: begin
                    if (SER_EN) begin
                        shift_q <= shift_q >> 1;
                        if (last_bit) begin
                            cnt_q  <= '0;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= SER_IDLE;
                        end else begin
                            cnt_q <= cnt_q + LEN_W'(1);
                        end
                    end
                end
                default: state <= SER_IDLE;
            endcase
        end
    end

    assign DATA_READY = ~buf_full & ~RST;
    assign WORD_AVAIL = buf_full;
    assign SER_DATA   = (state == SER_SHIFT) & shift_q[0];
    assign SER_BUSY   = busy_q;
    assign SER_DONE   = done_q;

`ifdef UART_SER_PARITY_EN
    logic par_next;
    logic par_q;

    uart_ser_parity #(
        .DATA_WIDTH (DATA_WIDTH),
        .LEN_W      (LEN_W)
    ) u_parity (
        .data (buf_q),
        .len  (len_eff),
        .odd  (CFG_PAR_ODD),
        .par  (par_next)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            par_q <= 1'b0;
        end else if (load_fire) begin
            par_q <= par_next;
        end
    end

    assign PAR_BIT = par_q;
`else
    logic unused_par_odd;
    assign unused_par_odd = CFG_PAR_ODD;
    assign PAR_BIT        = 1'b0;
`endif

endmodule
